// File: rtl/tx_cfg_ctrl.sv
// JESD204 tx configuration controller: shadow ILA table, sequential FCHK, validation,
// then tx reset hold and atomic apply of the active link-configuration table.
//
// state   | meaning
// S_IDLE  | shadow writable, waiting for commit
// S_CHECK | 13 accumulate cycles, then one evaluate cycle
// S_HOLD  | tx held in reset for HOLD_CYCLES
// S_APPLY | active table loaded, load/done pulsing
module tx_cfg_ctrl #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [3:0]       i_wr_addr,
  input  logic [7:0]       i_wr_data,
  output logic             o_wr_rdy,
  input  logic             i_commit,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cfg_err,
  output logic [1:0]       o_err_code,
  output logic [13:0][7:0] o_link_cfg,
  output logic             o_load_setup,
  output logic             o_tx_rst_n
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_HOLD, S_APPLY} state_t;

  state_t           r_state;
  logic [7:0]       r_shadow [0:12];
  logic [13:0][7:0] r_link;
  logic [3:0]       r_idx;
  logic [8:0]       r_acc;
  logic [7:0]       r_hold_cnt;
  logic             r_wr_rdy, r_busy, r_done, r_cfg_err, r_load, r_tx_rst_n;
  logic [1:0]       r_err_code;

  logic [7:0]       w_cur_oct;
  logic [8:0]       w_oct_sum;
  logic [8:0]       w_fp, w_kp, w_prod;
  logic             w_f_ok;
  logic [1:0]       w_err;

  function automatic logic [7:0] f_mask(input int idx);
    case (idx)
      2:       f_mask = 8'h7F;
      3, 10:   f_mask = 8'h9F;
      5:       f_mask = 8'h1F;
      7:       f_mask = 8'hDF;
      default: f_mask = 8'hFF;
    endcase
  endfunction

  // Sum of the individual field values, not of the raw octet.
  function automatic logic [8:0] f_field_sum(input logic [3:0] idx, input logic [7:0] v);
    case (idx)
      4'd1:        f_field_sum = 9'(v[7:4]) + 9'(v[3:0]);
      4'd2:        f_field_sum = 9'(v[6]) + 9'(v[5]) + 9'(v[4:0]);
      4'd3, 4'd10: f_field_sum = 9'(v[7]) + 9'(v[4:0]);
      4'd5:        f_field_sum = 9'(v[4:0]);
      4'd7:        f_field_sum = 9'(v[7:6]) + 9'(v[4:0]);
      4'd8, 4'd9:  f_field_sum = 9'(v[7:5]) + 9'(v[4:0]);
      default:     f_field_sum = 9'(v);
    endcase
  endfunction

  always_comb begin
    w_cur_oct = '0;
    for (int i = 0; i < 13; i++)
      if (r_idx == 4'(i)) w_cur_oct = r_shadow[i];
  end

  assign w_oct_sum = f_field_sum(r_idx, w_cur_oct);
  assign w_f_ok    = (r_shadow[4] == 8'd0) || (r_shadow[4] == 8'd1) ||
                     (r_shadow[4] == 8'd3) || (r_shadow[4] == 8'd7);
  assign w_fp      = 9'(r_shadow[4]) + 9'd1;
  assign w_kp      = 9'(r_shadow[5][4:0]) + 9'd1;
  assign w_prod    = w_fp * w_kp;
  assign w_err     = !w_f_ok                ? 2'd1 :
                     (w_prod < 9'd17)       ? 2'd2 :
                     ((r_shadow[9][7:5] != 3'd1) || (r_shadow[8][7:5] != 3'd1)) ? 2'd3 :
                     2'd0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < 13; i++) r_shadow[i] <= '0;
      r_link     <= '0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_hold_cnt <= '0;
      r_wr_rdy   <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_err_code <= '0;
      r_load     <= 1'b0;
      r_tx_rst_n <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_wr_en && (i_wr_addr <= 4'd12)) r_shadow[i_wr_addr] <= i_wr_data;
          if (i_commit) begin
            r_state    <= S_CHECK;
            r_busy     <= 1'b1;
            r_wr_rdy   <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_err_code <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
          end
        end
        S_CHECK: begin
          if (r_idx != 4'd13) begin
            r_acc <= r_acc + w_oct_sum;
            r_idx <= r_idx + 4'd1;
          end else if (w_err != 2'd0) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_wr_rdy   <= 1'b1;
            r_done     <= 1'b1;
            r_cfg_err  <= 1'b1;
            r_err_code <= w_err;
          end else begin
            r_state    <= S_HOLD;
            r_tx_rst_n <= 1'b0;
            r_hold_cnt <= 8'(HOLD_CYCLES - 1);
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == 8'd0) begin
            r_state <= S_APPLY;
            for (int i = 0; i < 13; i++) r_link[i] <= r_shadow[i] & f_mask(i);
            r_link[13] <= r_acc[7:0];
            r_tx_rst_n <= 1'b1;
            r_load     <= 1'b1;
            r_done     <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - 8'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_wr_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign o_wr_rdy     = r_wr_rdy;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_cfg_err    = r_cfg_err;
  assign o_err_code   = r_err_code;
  assign o_link_cfg   = r_link;
  assign o_load_setup = r_load;
  assign o_tx_rst_n   = r_tx_rst_n;

endmodule

// File: tb/tb_tx_cfg_ctrl.sv
// Self-checking bench for tx_cfg_ctrl: field-table reference model, directed and random commits.
module tb_tx_cfg_ctrl;
  localparam int H = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_wr_en = 1'b0;
  logic [3:0]       i_wr_addr = '0;
  logic [7:0]       i_wr_data = '0;
  logic             i_commit = 1'b0;
  logic             o_wr_rdy, o_busy, o_done, o_cfg_err, o_load_setup, o_tx_rst_n;
  logic [1:0]       o_err_code;
  logic [13:0][7:0] o_link_cfg;

  int checks = 0;
  int failures = 0;

  // model state
  int               m_sh [13];
  logic [13:0][7:0] m_link;
  logic             m_txrst;

  // field descriptor table: octet, msb, lsb
  int fo [21] = '{0,1,1,2,2,2,3,3,4,5,6,7,7,8,8,9,9,10,10,11,12};
  int fh [21] = '{7,7,3,6,5,4,7,4,7,4,7,7,4,7,4,7,4,7,4,7,7};
  int fl [21] = '{0,4,0,6,5,0,7,0,0,0,0,6,0,5,0,5,0,7,0,0,0};

  tx_cfg_ctrl #(.HOLD_CYCLES(H)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .o_wr_rdy(o_wr_rdy), .i_commit(i_commit), .o_busy(o_busy),
    .o_done(o_done), .o_cfg_err(o_cfg_err), .o_err_code(o_err_code),
    .o_link_cfg(o_link_cfg), .o_load_setup(o_load_setup), .o_tx_rst_n(o_tx_rst_n)
  );

  always #5 i_clk = ~i_clk;

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 13; i++) m_sh[i] = 0;
    m_link  = '0;
    m_txrst = 1'b0;
  endtask

  task automatic expect_cfg(output logic [13:0][7:0] link, output int code);
    int sum, w, msk, f, k, prod;
    sum  = 0;
    link = '0;
    for (int i = 0; i < 21; i++) begin
      w   = fh[i] - fl[i] + 1;
      msk = ((1 << w) - 1) << fl[i];
      sum += (m_sh[fo[i]] >> fl[i]) % (1 << w);
      link[fo[i]] = link[fo[i]] | 8'(m_sh[fo[i]] & msk);
    end
    link[13] = 8'(sum % 256);
    f    = m_sh[4] + 1;
    k    = (m_sh[5] % 32) + 1;
    prod = (f * k) % 512;
    if (!(f == 1 || f == 2 || f == 4 || f == 8)) code = 1;
    else if (prod < 17)                          code = 2;
    else if ((m_sh[9] >> 5) != 1 || (m_sh[8] >> 5) != 1) code = 3;
    else                                         code = 0;
  endtask

  task automatic wr(input int a, input int d);
    i_wr_en   = 1'b1;
    i_wr_addr = 4'(a);
    i_wr_data = 8'(d);
    cycle();
    i_wr_en = 1'b0;
    if (a < 13) m_sh[a] = d;
  endtask

  task automatic load_base();
    int base [13] = '{'h5A,0,0,'h03,'h01,'h1F,'h03,'h0F,'h2F,'h20,0,0,0};
    for (int i = 0; i < 13; i++) wr(i, base[i]);
  endtask

  task automatic run_commit(input bit with_wr, input int a, input int d, input bit poke);
    logic [13:0][7:0] elink;
    int code;
    if (with_wr) begin
      i_wr_en   = 1'b1;
      i_wr_addr = 4'(a);
      i_wr_data = 8'(d);
      if (a < 13) m_sh[a] = d;
    end
    expect_cfg(elink, code);
    i_commit = 1'b1;
    cycle();
    i_commit = 1'b0;
    i_wr_en  = 1'b0;
    checks++;
    if ({o_busy, o_wr_rdy, o_cfg_err, o_err_code} !== 5'b10000) begin
      failures++;
      $display("FAIL commit_start busy/rdy/err got %b want 10000", {o_busy, o_wr_rdy, o_cfg_err, o_err_code});
    end
    for (int e = 1; e <= 13; e++) begin
      if (poke && e == 5) begin
        i_wr_en   = 1'b1;
        i_wr_addr = 4'($urandom_range(0, 12));
        i_wr_data = 8'($urandom);
        i_commit  = 1'b1;
      end
      cycle();
      i_wr_en  = 1'b0;
      i_commit = 1'b0;
    end
    checks++;
    if ({o_busy, o_done, o_tx_rst_n} !== {2'b10, m_txrst}) begin
      failures++;
      $display("FAIL check_phase busy/done/txrst got %b want %b", {o_busy, o_done, o_tx_rst_n}, {2'b10, m_txrst});
    end
    cycle(); // edge 14
    if (code != 0) begin
      checks++;
      if ({o_done, o_cfg_err, o_err_code, o_busy, o_wr_rdy, o_tx_rst_n} !== {2'b11, 2'(code), 2'b01, m_txrst}) begin
        failures++;
        $display("FAIL err_result done/err/code/busy/rdy/txrst got %b want %b",
                 {o_done, o_cfg_err, o_err_code, o_busy, o_wr_rdy, o_tx_rst_n}, {2'b11, 2'(code), 2'b01, m_txrst});
      end
      checks++;
      if (o_link_cfg !== m_link) begin
        failures++;
        $display("FAIL err_link_kept got %h want %h", o_link_cfg, m_link);
      end
      cycle();
      checks++;
      if ({o_done, o_busy, o_cfg_err} !== 3'b001) begin
        failures++;
        $display("FAIL err_after done/busy/err got %b want 001", {o_done, o_busy, o_cfg_err});
      end
    end else begin
      for (int e = 14; e < 14 + H; e++) begin
        checks++;
        if ({o_tx_rst_n, o_load_setup, o_done, o_busy} !== 4'b0001) begin
          failures++;
          $display("FAIL hold edge %0d txrst/load/done/busy got %b want 0001", e, {o_tx_rst_n, o_load_setup, o_done, o_busy});
        end
        cycle();
      end
      m_link  = elink;
      m_txrst = 1'b1;
      checks++;
      if ({o_tx_rst_n, o_load_setup, o_done, o_busy, o_cfg_err} !== 5'b11110) begin
        failures++;
        $display("FAIL apply txrst/load/done/busy/err got %b want 11110", {o_tx_rst_n, o_load_setup, o_done, o_busy, o_cfg_err});
      end
      checks++;
      if (o_link_cfg !== m_link) begin
        failures++;
        $display("FAIL apply_link got %h want %h", o_link_cfg, m_link);
      end
      cycle();
      checks++;
      if ({o_busy, o_wr_rdy, o_load_setup, o_done, o_tx_rst_n} !== 5'b01001) begin
        failures++;
        $display("FAIL post_apply busy/rdy/load/done/txrst got %b want 01001", {o_busy, o_wr_rdy, o_load_setup, o_done, o_tx_rst_n});
      end
    end
    cycle();
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL no_requeue busy got %b want 0", o_busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({o_tx_rst_n, o_wr_rdy, o_busy, o_done, o_load_setup, o_cfg_err, o_err_code} !== 8'b01000000) begin
      failures++;
      $display("FAIL reset_outputs got %b want 01000000", {o_tx_rst_n, o_wr_rdy, o_busy, o_done, o_load_setup, o_cfg_err, o_err_code});
    end
    checks++;
    if (o_link_cfg !== '0) begin
      failures++;
      $display("FAIL reset_link got %h want 0", o_link_cfg);
    end
  endtask

  task automatic test_directed_pass();
    load_base();
    run_commit(1'b0, 0, 0, 1'b0);
    checks++;
    if (o_link_cfg[13] !== 8'hA0) begin
      failures++;
      $display("FAIL fchk_base got %h want a0", o_link_cfg[13]);
    end
  endtask

  task automatic test_errors();
    wr(4, 'h02);
    run_commit(1'b0, 0, 0, 1'b0);
    checks++;
    if (o_err_code !== 2'd1) begin
      failures++;
      $display("FAIL err_illegal_f got %0d want 1", o_err_code);
    end
    wr(4, 'h00);
    wr(5, 'h0F);
    run_commit(1'b0, 0, 0, 1'b0);
    checks++;
    if (o_err_code !== 2'd2) begin
      failures++;
      $display("FAIL err_fk16 got %0d want 2", o_err_code);
    end
    wr(5, 'h1F);
    wr(9, 'h40);
    wr(4, 'h02);
    run_commit(1'b0, 0, 0, 1'b0);
    checks++;
    if (o_err_code !== 2'd1) begin
      failures++;
      $display("FAIL err_priority got %0d want 1", o_err_code);
    end
  endtask

  task automatic test_same_cycle();
    load_base();
    run_commit(1'b1, 0, 'h5B, 1'b1);
    checks++;
    if (o_link_cfg[13] !== 8'hA1) begin
      failures++;
      $display("FAIL fchk_same_cycle got %h want a1", o_link_cfg[13]);
    end
    run_commit(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_hold();
    i_commit = 1'b1;
    cycle();
    i_commit = 1'b0;
    for (int e = 1; e <= 16; e++) cycle();
    #2 i_rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({o_tx_rst_n, o_wr_rdy, o_busy, o_done, o_load_setup, o_cfg_err, o_err_code} !== 8'b01000000) begin
      failures++;
      $display("FAIL midhold_rst got %b want 01000000", {o_tx_rst_n, o_wr_rdy, o_busy, o_done, o_load_setup, o_cfg_err, o_err_code});
    end
    checks++;
    if (o_link_cfg !== '0) begin
      failures++;
      $display("FAIL midhold_link got %h want 0", o_link_cfg);
    end
    cycle();
    i_rst = 1'b0;
    cycle();
    run_commit(1'b0, 0, 0, 1'b0);
    load_base();
    run_commit(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int fsel [6] = '{0, 1, 3, 7, 2, 5};
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 13; i++) wr(i, int'($urandom_range(0, 255)));
      wr(int'($urandom_range(13, 15)), int'($urandom_range(0, 255)));
      wr(4, fsel[$urandom_range(0, 5)]);
      if ($urandom_range(0, 3) != 0) wr(8, (1 << 5) | int'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) != 0) wr(9, (1 << 5) | int'($urandom_range(0, 31)));
      run_commit(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    model_reset();
    #12 i_rst = 1'b0;
    cycle();
    test_reset();
    test_directed_pass();
    test_errors();
    test_same_cycle();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
